// File: rtl/bp_pkg.sv
// Shared types and parameter helpers for the branch predictor BTB and its direction counters.
package bp_pkg;

  localparam int unsigned CtrMaxW = 4;
  localparam int unsigned TagMaxW = 30;

  // Fields are sized for the widest legal configuration; narrower configs zero-extend.
  typedef struct packed {
    logic               valid;
    logic [TagMaxW-1:0] tag;
    logic [31:0]        target;
    logic [CtrMaxW-1:0] ctr;
    logic               is_jump;
  } bp_entry_t;

  function automatic int unsigned idx_w(int unsigned entries);
    return $clog2(entries);
  endfunction

  function automatic int unsigned tag_w(int unsigned entries);
    return 30 - $clog2(entries);
  endfunction

  function automatic logic [CtrMaxW-1:0] weak_taken(int unsigned ctr_bits);
    return CtrMaxW'(1 << (ctr_bits - 1));
  endfunction

  function automatic logic [CtrMaxW-1:0] ctr_max(int unsigned ctr_bits);
    return CtrMaxW'((1 << ctr_bits) - 1);
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-state logic of a CTR_BITS-wide saturating up/down direction counter.
module bp_sat_ctr
  import bp_pkg::*;
#(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr_i,
  input  logic                up_i,
  output logic [CTR_BITS-1:0] ctr_o
);

  localparam logic [CTR_BITS-1:0] CtrTop = CTR_BITS'(ctr_max(CTR_BITS));

  always_comb begin
    ctr_o = ctr_i;
    if (up_i) begin
      if (ctr_i != CtrTop) ctr_o = ctr_i + CTR_BITS'(1);
    end else if (ctr_i != '0) begin
      ctr_o = ctr_i - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters, EX-stage training and perf counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned PRED_EN  = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_pc_if,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_upd_vld,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_is_jump,
  input  logic        i_upd_pred_taken,
  input  logic [31:0] i_upd_pred_target,
  output logic        o_mispred,
  output logic [31:0] o_redirect_pc,
  input  logic        i_clr,
  output logic [31:0] o_ctrl_cnt,
  output logic [31:0] o_mispred_cnt
);

  localparam int unsigned IdxW = idx_w(ENTRIES);

  bp_entry_t table_q [ENTRIES];
  bp_entry_t table_d [ENTRIES];
  logic [31:0] ctrl_cnt_q, ctrl_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  logic [IdxW-1:0]    if_idx, upd_idx;
  logic [TagMaxW-1:0] if_tag, upd_tag;
  bp_entry_t          if_ent, upd_ent;
  logic               if_hit, upd_hit;
  logic [CTR_BITS-1:0] upd_ctr_cur, upd_ctr_nxt;

  assign if_idx  = i_pc_if[IdxW+1:2];
  assign if_tag  = TagMaxW'(i_pc_if[31:IdxW+2]);
  assign upd_idx = i_upd_pc[IdxW+1:2];
  assign upd_tag = TagMaxW'(i_upd_pc[31:IdxW+2]);

  // Lookups read the registered table, so a same-cycle update is not visible yet.
  assign if_ent  = table_q[if_idx];
  assign upd_ent = table_q[upd_idx];
  assign if_hit  = if_ent.valid && (if_ent.tag == if_tag);
  assign upd_hit = upd_ent.valid && (upd_ent.tag == upd_tag);

  assign o_pred_taken  = (PRED_EN != 0) && if_hit && (if_ent.is_jump || if_ent.ctr[CTR_BITS-1]);
  assign o_pred_target = o_pred_taken ? if_ent.target : i_pc_if + 32'd4;

  assign o_mispred = i_upd_vld && ((i_upd_taken != i_upd_pred_taken) ||
                                   (i_upd_taken && (i_upd_target != i_upd_pred_target)));
  assign o_redirect_pc = i_upd_taken ? i_upd_target : i_upd_pc + 32'd4;

  assign upd_ctr_cur = upd_ent.ctr[CTR_BITS-1:0];

  bp_sat_ctr #(
    .CTR_BITS (CTR_BITS)
  ) u_upd_ctr (
    .ctr_i (upd_ctr_cur),
    .up_i  (i_upd_taken),
    .ctr_o (upd_ctr_nxt)
  );

  always_comb begin
    table_d = table_q;
    if (i_clr) begin
      for (int i = 0; i < int'(ENTRIES); i++) table_d[i].valid = 1'b0;
    end else if (i_upd_vld) begin
      if (upd_hit) begin
        table_d[upd_idx].ctr = CtrMaxW'(upd_ctr_nxt);
        if (i_upd_taken) begin
          table_d[upd_idx].target  = i_upd_target;
          table_d[upd_idx].is_jump = i_upd_is_jump;
        end
      end else if (i_upd_taken) begin
        table_d[upd_idx] = '{valid:   1'b1,
                             tag:     upd_tag,
                             target:  i_upd_target,
                             ctr:     weak_taken(CTR_BITS),
                             is_jump: i_upd_is_jump};
      end
    end
  end

  always_comb begin
    ctrl_cnt_d    = ctrl_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (i_upd_vld && (ctrl_cnt_q != '1)) ctrl_cnt_d = ctrl_cnt_q + 32'd1;
    if (o_mispred && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) table_q[i] <= '0;
      ctrl_cnt_q    <= '0;
      mispred_cnt_q <= '0;
    end else begin
      table_q       <= table_d;
      ctrl_cnt_q    <= ctrl_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign o_ctrl_cnt    = ctrl_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: a spec-level model predicts each cycle's outputs; a negedge monitor checks.
module tb_branch_predictor;

  localparam int unsigned Entries = 16;
  localparam int unsigned IdxW    = 4;
  localparam int          WeakT   = 2;
  localparam int          CtrTop  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_if;
  logic        upd_vld, upd_taken, upd_jump, upd_ptk, clr;
  logic [31:0] upd_pc, upd_tgt, upd_ptgt;

  logic        p_tk0, p_tk1, misp0, misp1;
  logic [31:0] p_tgt0, p_tgt1, redir0, redir1, cc0, cc1, mc0, mc1;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(16), .CTR_BITS(2), .PRED_EN(1)) dut0 (
    .i_clk(clk), .i_reset(rst_n), .i_pc_if(pc_if), .o_pred_taken(p_tk0), .o_pred_target(p_tgt0),
    .i_upd_vld(upd_vld), .i_upd_pc(upd_pc), .i_upd_taken(upd_taken), .i_upd_target(upd_tgt),
    .i_upd_is_jump(upd_jump), .i_upd_pred_taken(upd_ptk), .i_upd_pred_target(upd_ptgt),
    .o_mispred(misp0), .o_redirect_pc(redir0), .i_clr(clr), .o_ctrl_cnt(cc0),
    .o_mispred_cnt(mc0)
  );

  branch_predictor #(.ENTRIES(16), .CTR_BITS(2), .PRED_EN(0)) dut1 (
    .i_clk(clk), .i_reset(rst_n), .i_pc_if(pc_if), .o_pred_taken(p_tk1), .o_pred_target(p_tgt1),
    .i_upd_vld(upd_vld), .i_upd_pc(upd_pc), .i_upd_taken(upd_taken), .i_upd_target(upd_tgt),
    .i_upd_is_jump(upd_jump), .i_upd_pred_taken(upd_ptk), .i_upd_pred_target(upd_ptgt),
    .o_mispred(misp1), .o_redirect_pc(redir1), .i_clr(clr), .o_ctrl_cnt(cc1),
    .o_mispred_cnt(mc1)
  );

  typedef struct {
    logic [31:0] pc;
    logic        ptk;
    logic [31:0] ptgt;
    logic        vld;
    logic        misp;
    logic [31:0] redir;
    logic [31:0] cc;
    logic [31:0] mc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: one slot per index, counter as a plain clamped integer.
  bit          m_valid [Entries];
  logic [31:0] m_tag   [Entries];
  logic [31:0] m_tgt   [Entries];
  int          m_ctr   [Entries];
  bit          m_jump  [Entries];
  logic [31:0] m_cc, m_mc;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % Entries);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IdxW + 2);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_tag[slot(pc)] == tag_of(pc));
  endfunction

  function automatic bit exp_misp();
    return upd_vld && ((upd_taken != upd_ptk) || (upd_taken && (upd_tgt != upd_ptgt)));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(Entries); i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 0;
    end
    m_cc = 0;
    m_mc = 0;
  endtask

  task automatic model_edge(input bit misp);
    int s;
    s = slot(upd_pc);
    if (upd_vld) m_cc = m_cc + 1;
    if (misp) m_mc = m_mc + 1;
    if (clr) begin
      for (int i = 0; i < int'(Entries); i++) m_valid[i] = 1'b0;
    end else if (upd_vld) begin
      if (m_hit(upd_pc)) begin
        m_ctr[s] = upd_taken ? ((m_ctr[s] < CtrTop) ? m_ctr[s] + 1 : CtrTop)
                             : ((m_ctr[s] > 0) ? m_ctr[s] - 1 : 0);
        if (upd_taken) begin
          m_tgt[s]  = upd_tgt;
          m_jump[s] = upd_jump;
        end
      end else if (upd_taken) begin
        m_valid[s] = 1'b1;
        m_tag[s]   = tag_of(upd_pc);
        m_tgt[s]   = upd_tgt;
        m_ctr[s]   = WeakT;
        m_jump[s]  = upd_jump;
      end
    end
  endtask

  // Called just after a rising edge: drive, predict, then advance the model across the next edge.
  task automatic step(input bit rst, input logic [31:0] pc, input bit vld, input logic [31:0] upc,
                      input bit tk, input logic [31:0] tgt, input bit jmp, input bit ptk,
                      input logic [31:0] ptgt, input bit c);
    exp_t e;
    bit   hit, misp;
    int   s;
    rst_n = rst; pc_if = pc; upd_vld = vld; upd_pc = upc; upd_taken = tk; upd_tgt = tgt;
    upd_jump = jmp; upd_ptk = ptk; upd_ptgt = ptgt; clr = c;
    if (!rst) model_reset();
    s     = slot(pc);
    hit   = m_hit(pc);
    misp  = exp_misp();
    e.pc  = pc;
    e.ptk = hit && (m_jump[s] || (m_ctr[s] >= WeakT));
    e.ptgt  = e.ptk ? m_tgt[s] : pc + 32'd4;
    e.vld   = vld;
    e.misp  = misp;
    e.redir = tk ? tgt : upc + 32'd4;
    e.cc    = m_cc;
    e.mc    = m_mc;
    q.push_back(e);
    @(posedge clk);
    if (rst) model_edge(misp);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] upc, input bit tk,
                     input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    step(1'b1, pc, 1'b1, upc, tk, tgt, 1'b0, ptk, ptgt, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (pc_if=%h t=%0t)", name, act, exp, pc_if, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pred_taken",     32'(p_tk0), 32'(e.ptk));
        chk("pred_target",    p_tgt0,     e.ptgt);
        chk("mispred",        32'(misp0), 32'(e.misp));
        chk("ctrl_cnt",       cc0,        e.cc);
        chk("mispred_cnt",    mc0,        e.mc);
        chk("static_taken",   32'(p_tk1), 32'h0);
        chk("static_target",  p_tgt1,     e.pc + 32'd4);
        chk("static_mispred", 32'(misp1), 32'(e.misp));
        chk("static_ctrl",    cc1,        e.cc);
        if (e.vld) begin
          chk("redirect_pc",        redir0, e.redir);
          chk("static_redirect_pc", redir1, e.redir);
        end
      end
    end
  end

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0100;
      1: return 32'h0000_0140;
      2: return 32'h0000_0180;
      3: return 32'h0000_0104;
      4: return 32'hFFFF_FFFC;
      5: return 32'h8000_0100;
      6: return 32'h0000_01C0;
      default: return $urandom() & 32'hFFFF_FFFC;
    endcase
  endfunction

  function automatic logic [31:0] pick_tgt();
    case ($urandom_range(0, 2))
      0: return 32'h0000_0200;
      1: return 32'h0000_0300;
      default: return 32'h0000_0400;
    endcase
  endfunction

  initial begin : stim
    int waited;
    rst_n = 1'b0; pc_if = 0; upd_vld = 0; upd_pc = 0; upd_taken = 0; upd_tgt = 0;
    upd_jump = 0; upd_ptk = 0; upd_ptgt = 0; clr = 0;
    model_reset();
    @(posedge clk); #1;

    // Reset state, including an update presented while reset is held.
    step(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
    lookup(32'h100);

    // Allocate, then predict taken.
    upd(32'h100, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    lookup(32'h100);

    // Train down to zero, then once more to show no wrap.
    for (int i = 0; i < 5; i++) upd(32'h100, 32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
    lookup(32'h100);

    // Alias at the same index; same-cycle lookup sees the old contents.
    upd(32'h140, 32'h140, 1'b1, 32'h300, 1'b0, 32'h0);
    lookup(32'h100);
    lookup(32'h140);

    // Clear beats a simultaneous allocating update.
    step(1'b1, 32'h140, 1'b1, 32'h180, 1'b1, 32'h500, 1'b1, 1'b0, 32'h0, 1'b1);
    lookup(32'h140);
    lookup(32'h180);

    // Redirect wraps around the top of the address space.
    upd(32'h0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h100);
    lookup(32'hFFFF_FFFC);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] upc, tgt;
      bit tk;
      upc = pick_pc();
      tgt = pick_tgt();
      tk  = $urandom_range(0, 2) != 0;
      step(1'b1, pick_pc(), $urandom_range(0, 3) != 0, upc, tk, tgt, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? tgt : pick_tgt(),
           $urandom_range(0, 39) == 0);
    end

    // Reset landing on an update cycle discards it.
    upd(32'h100, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
    lookup(32'h100);
    lookup(32'h100);

    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, 16, number of BTB/counter entries (power of 2, 4..256).
REQ-002 SHALL have parameter CTR_BITS, 2, width of each saturating direction counter (1..4).
REQ-003 SHALL have parameter PRED_EN, 1, 1 = dynamic prediction, 0 = static not-taken (table still updated).
REQ-004 SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port i_reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_pc_if  input  32  fetch PC to predict.
REQ-007 SHALL have port o_pred_taken  output  1  predicted taken for i_pc_if.
REQ-008 SHALL have port o_pred_target  output  32  predicted next PC (target if taken, else i_pc_if+4).
REQ-009 SHALL have ports i_upd_vld (1), i_upd_pc (32), i_upd_taken (1), i_upd_target (32), i_upd_is_jump (1), i_upd_pred_taken (1), i_upd_pred_target (32), all inputs: resolved control instruction from EX.
REQ-010 SHALL have port o_mispred  output  1  EX resolution disagrees with carried prediction.
REQ-011 SHALL have port o_redirect_pc  output  32  correct next PC (i_upd_target if taken, else i_upd_pc+4).
REQ-012 SHALL have port i_clr  input  1  synchronous invalidate of all entries.
REQ-013 SHALL have ports o_ctrl_cnt and o_mispred_cnt  output  32 each  saturating performance counters.

Function
REQ-014 Index SHALL be pc[IDX+1:2], IDX=log2(ENTRIES); tag SHALL be pc[31:IDX+2]; entry = valid, tag, target[31:0], counter, is_jump.
REQ-015 Lookup SHALL be combinational, zero latency: hit = valid & tag match; o_pred_taken = PRED_EN & hit & (is_jump | counter MSB).
REQ-016 o_mispred SHALL equal i_upd_vld & ((i_upd_taken != i_upd_pred_taken) | (i_upd_taken & i_upd_target != i_upd_pred_target)); 0 when i_upd_vld=0.
REQ-017 On i_upd_vld with hit: counter +1 if taken, -1 if not, saturating at 0 and 2^CTR_BITS-1 (no wrap); target and is_jump written when taken.
REQ-018 On i_upd_vld with miss and taken: allocate (overwrite index), valid=1, counter = WEAK_TAKEN (2^(CTR_BITS-1)), write tag/target/is_jump.
REQ-019 On i_upd_vld with miss and not taken: no table change.
REQ-020 Table writes SHALL take effect at the clock edge; a same-cycle lookup of the index being updated SHALL return pre-update contents.
REQ-021 i_clr SHALL clear all valid bits at the edge and take priority over a simultaneous update; performance counters unaffected.
REQ-022 o_ctrl_cnt SHALL increment on each i_upd_vld, o_mispred_cnt on each o_mispred; both hold at 32'hFFFF_FFFF.
REQ-023 PC+4 additions SHALL wrap modulo 2^32.

Reset
REQ-024 While i_reset=0, all valid bits, counters, and performance counters SHALL be 0 immediately (asynchronous), so o_pred_taken=0, o_pred_target=i_pc_if+4, o_ctrl_cnt=o_mispred_cnt=0.
REQ-025 Reset asserted mid-update SHALL discard the update; release SHALL be synchronized to i_clk by the caller; table target/tag contents need not be reset.

Structure
REQ-026 Shared package bp_pkg SHALL hold the entry struct typedef, WEAK_TAKEN and counter-max functions of CTR_BITS, and the index/tag width functions.
REQ-027 One sub-module bp_sat_ctr (CTR_BITS-wide saturating up/down counter next-state logic) SHALL be instantiated per update path.

Verification
REQ-028 Reset then i_pc_if=0x100 -> o_pred_taken=0, o_pred_target=0x104, both counters 0.
REQ-029 Update pc=0x100 taken target=0x200, pred_taken=0 -> o_mispred=1, o_redirect_pc=0x200, o_mispred_cnt=1; next cycle lookup 0x100 -> taken, target 0x200.
REQ-030 Four not-taken updates at 0x100 (CTR_BITS=2) -> counter 0, lookup predicts not-taken; fifth not-taken keeps counter 0 (no wrap).
REQ-031 Alias: after allocating 0x100, taken update pc=0x140 (ENTRIES=16) -> lookup 0x100 misses, 0x140 hits; same-cycle lookup 0x140 during its own allocation returns miss.
REQ-032 i_clr asserted with simultaneous taken update -> all lookups miss next cycle, o_ctrl_cnt still increments.
REQ-033 PRED_EN=0: any trained entry -> o_pred_taken=0; i_upd_pc=0xFFFF_FFFC not taken -> o_redirect_pc=0x0000_0000.
